// File: rtl/branch_resolve.sv
// branch_resolve: execute-stage control-flow resolver.
// Decides taken/not-taken for the instruction in EX, computes the redirect
// target, produces the R7 link write for JAL/JALR, and squashes the younger
// instructions fetched under predict-not-taken through a small flush FSM.
//
// Handshake: an instruction is consumed when in_valid & !stall & state==IDLE.
// The response appears one cycle later on registered outputs. While stall is
// high every register holds, so redirect/link_we pulses and flush must be
// qualified with !stall by the consumer.
module branch_resolve #(
  parameter int WIDTH       = 16,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             stall,
  input  logic [4:0]       aluOp,
  input  logic             alu_cond,
  input  logic [WIDTH-1:0] pc_plus2,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] rs_val,
  output logic             redirect,
  output logic [WIDTH-1:0] target,
  output logic             flush,
  output logic             link_we,
  output logic [WIDTH-1:0] link_data,
  output logic             err,
  output logic [15:0]      taken_cnt,
  output logic [3:0]       dbg_state
);

  localparam logic [4:0] OP_BEQZ = 5'b01100;
  localparam logic [4:0] OP_BNEZ = 5'b01101;
  localparam logic [4:0] OP_BLTZ = 5'b01110;
  localparam logic [4:0] OP_BGEZ = 5'b01111;
  localparam logic [4:0] OP_J    = 5'b00100;
  localparam logic [4:0] OP_JAL  = 5'b00110;
  localparam logic [4:0] OP_JR   = 5'b00101;
  localparam logic [4:0] OP_JALR = 5'b00111;

  localparam logic [2:0] CNT_LOAD = 3'(FLUSH_DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t     state;
  logic [2:0] cnt;

  logic             op_legal;
  logic             op_taken;
  logic             op_link;
  logic             op_use_rs;
  logic [WIDTH-1:0] next_target;
  logic             accept;

  // Debug view of the FSM: {state, cnt}.
  assign dbg_state = {state, cnt};

  assign accept = in_valid && !stall && (state == IDLE);

  // Opcode decode and target arithmetic for the instruction in EX.
  always_comb begin
    op_legal  = 1'b0;
    op_taken  = 1'b0;
    op_link   = 1'b0;
    op_use_rs = 1'b0;
    case (aluOp)
      OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ: begin
        op_legal = 1'b1;
        op_taken = alu_cond;
      end
      OP_J: begin
        op_legal = 1'b1;
        op_taken = 1'b1;
      end
      OP_JAL: begin
        op_legal = 1'b1;
        op_taken = 1'b1;
        op_link  = 1'b1;
      end
      OP_JR: begin
        op_legal  = 1'b1;
        op_taken  = 1'b1;
        op_use_rs = 1'b1;
      end
      OP_JALR: begin
        op_legal  = 1'b1;
        op_taken  = 1'b1;
        op_link   = 1'b1;
        op_use_rs = 1'b1;
      end
      default: begin
        op_legal = 1'b0;
      end
    endcase
    // Modulo 2^WIDTH; wrap-around is intentional.
    next_target = (op_use_rs ? rs_val : pc_plus2) + imm;
  end

  // Flush FSM plus all registered outputs; reset dominates stall, stall freezes everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      redirect  <= 1'b0;
      target    <= '0;
      flush     <= 1'b0;
      link_we   <= 1'b0;
      link_data <= '0;
      err       <= 1'b0;
      taken_cnt <= 16'd0;
    end else if (!stall) begin
      redirect <= 1'b0;
      link_we  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!op_legal) begin
              // Illegal opcode behaves as a not-taken instruction with no link.
              err <= 1'b1;
            end else if (op_taken) begin
              redirect <= 1'b1;
              target   <= next_target;
              flush    <= 1'b1;
              state    <= FLUSH;
              cnt      <= CNT_LOAD;
              if (taken_cnt != 16'hFFFF) begin
                taken_cnt <= taken_cnt + 16'd1;
              end
              if (op_link) begin
                link_we   <= 1'b1;
                link_data <= pc_plus2;
              end
            end
          end
        end
        FLUSH: begin
          // Younger instructions arriving here are being squashed; in_valid is ignored.
          if (cnt == 3'd0) begin
            state <= IDLE;
            flush <= 1'b0;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: begin
          state <= IDLE;
          flush <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed test-plan scenarios followed by randomized
// traffic, checked against a cycle-level behavioural model with a scoreboard.
module tb_branch_resolve;

  localparam int W  = 16;
  localparam int FD = 2;

  localparam logic [4:0] BEQZ = 5'b01100;
  localparam logic [4:0] BNEZ = 5'b01101;
  localparam logic [4:0] BLTZ = 5'b01110;
  localparam logic [4:0] BGEZ = 5'b01111;
  localparam logic [4:0] J    = 5'b00100;
  localparam logic [4:0] JAL  = 5'b00110;
  localparam logic [4:0] JR   = 5'b00101;
  localparam logic [4:0] JALR = 5'b00111;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid;
  logic         stall;
  logic [4:0]   aluOp;
  logic         alu_cond;
  logic [W-1:0] pc_plus2;
  logic [W-1:0] imm;
  logic [W-1:0] rs_val;
  logic         redirect;
  logic [W-1:0] target;
  logic         flush;
  logic         link_we;
  logic [W-1:0] link_data;
  logic         err;
  logic [15:0]  taken_cnt;
  logic [3:0]   dbg_state;

  branch_resolve #(.WIDTH(W), .FLUSH_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall),
    .aluOp(aluOp), .alu_cond(alu_cond), .pc_plus2(pc_plus2), .imm(imm),
    .rs_val(rs_val), .redirect(redirect), .target(target), .flush(flush),
    .link_we(link_we), .link_data(link_data), .err(err),
    .taken_cnt(taken_cnt), .dbg_state(dbg_state)
  );

  // ---------------- counters ----------------
  int n_vec = 0;
  int n_mis = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Scoreboard entry: {link, link_data, target}
  logic [2*W:0] exp_q[$];
  int           flush_left = 0;   // unstalled flush cycles still owed
  bit           exp_redir  = 1'b0;
  bit           err_m      = 1'b0;
  int           tcnt_m     = 0;

  function automatic bit is_legal(input logic [4:0] op);
    return op inside {BEQZ, BNEZ, BLTZ, BGEZ, J, JAL, JR, JALR};
  endfunction

  function automatic bit is_taken(input logic [4:0] op, input logic c);
    return (op inside {J, JAL, JR, JALR}) || ((op inside {BEQZ, BNEZ, BLTZ, BGEZ}) && c);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      flush_left = 0;
      exp_redir  = 1'b0;
      err_m      = 1'b0;
      tcnt_m     = 0;
      exp_q.delete();
    end else if (!stall) begin
      exp_redir = 1'b0;
      if (flush_left > 0) begin
        flush_left--;
      end else if (in_valid) begin
        if (!is_legal(aluOp)) begin
          err_m = 1'b1;
        end else if (is_taken(aluOp, alu_cond)) begin
          logic         lnk;
          logic [W-1:0] base;
          lnk  = aluOp inside {JAL, JALR};
          base = (aluOp inside {JR, JALR}) ? rs_val : pc_plus2;
          exp_q.push_back({lnk, pc_plus2, W'(base + imm)});
          exp_redir  = 1'b1;
          flush_left = FD;
          if (tcnt_m < 65535) tcnt_m++;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      chk("flush", 32'(flush), 32'(flush_left > 0));
      chk("redirect", 32'(redirect), 32'(exp_redir));
      chk("err", 32'(err), 32'(err_m));
      chk("taken_cnt", 32'(taken_cnt), 32'(tcnt_m));
      if (redirect && !stall) begin
        if (exp_q.size() == 0) begin
          chk("redirect_unexpected", 32'(redirect), 32'd0);
        end else begin
          logic [2*W:0] e;
          e = exp_q.pop_front();
          chk("target", 32'(target), 32'(e[W-1:0]));
          chk("link_we", 32'(link_we), 32'(e[2*W]));
          if (e[2*W]) chk("link_data", 32'(link_data), 32'(e[2*W-1:W]));
        end
      end
      if (!redirect) chk("link_we_idle", 32'(link_we), 32'd0);
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic s, input logic [4:0] op,
                       input logic c, input logic [W-1:0] pc,
                       input logic [W-1:0] im, input logic [W-1:0] rs);
    in_valid = v;
    stall    = s;
    aluOp    = op;
    alu_cond = c;
    pc_plus2 = pc;
    imm      = im;
    rs_val   = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 5'd0, 1'b0, '0, '0, '0);
  endtask

  // ---------------- stimulus ----------------
  logic [4:0] ops [8] = '{BEQZ, BNEZ, BLTZ, BGEZ, J, JAL, JR, JALR};

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; stall = 1'b0; aluOp = '0; alu_cond = 1'b0;
    pc_plus2 = '0; imm = '0; rs_val = '0;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    rst_n  = 1'b1;

    // Reset values
    @(negedge clk);
    chk("rst_redirect", 32'(redirect), 32'd0);
    chk("rst_target", 32'(target), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_link_we", 32'(link_we), 32'd0);
    chk("rst_link_data", 32'(link_data), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_taken_cnt", 32'(taken_cnt), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1;

    // Taken BEQZ with negative displacement
    drive(1, 0, BEQZ, 1, 16'h0010, 16'hFFF8, 16'h0000);
    idle(4);

    // Three back-to-back not-taken BNEZ
    for (int i = 0; i < 3; i++) drive(1, 0, BNEZ, 0, 16'h0020 + 16'(2*i), 16'h0040, '0);
    idle(2);

    // JALR with wrap-around target, followed by JALs that must be squashed
    drive(1, 0, JALR, 0, 16'h0100, 16'h0004, 16'hFFFE);
    drive(1, 0, JAL, 0, 16'h0102, 16'h0010, '0);
    drive(1, 0, JAL, 0, 16'h0104, 16'h0010, '0);
    idle(3);

    // J followed by a three-cycle stall
    drive(1, 0, J, 0, 16'h0200, 16'h0020, '0);
    for (int i = 0; i < 3; i++) drive(0, 1, 5'd0, 0, '0, '0, '0);
    idle(4);

    // Reset during the first flush cycle, then a taken BLTZ right after
    drive(1, 0, BEQZ, 1, 16'h0300, 16'h0008, '0);
    rst_n = 1'b0;
    drive(0, 0, 5'd0, 0, '0, '0, '0);
    rst_n = 1'b1;
    drive(1, 0, BLTZ, 1, 16'h0400, 16'h0002, '0);
    idle(4);

    // Illegal opcode sets a sticky error
    drive(1, 0, 5'b00011, 1, 16'h0500, 16'h0002, '0);
    idle(2);
    drive(1, 0, J, 0, 16'h0600, 16'h0002, '0);
    idle(4);

    // Randomized traffic with stalls, occasional illegal ops and resets
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] op;
      op = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(0, 31)) : ops[$urandom_range(0, 7)];
      rst_n = ($urandom_range(0, 199) != 0);
      drive(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 4) == 0), op,
            logic'($urandom_range(0, 1)), W'($urandom), W'($urandom), W'($urandom));
    end
    rst_n = 1'b1;
    idle(8);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Execute-stage control-flow resolver sitting directly downstream of the branch ALU-control decoder and the ALU. It consumes the 5-bit control-flow opcode plus the ALU's condition result for the instruction in EX. It decides taken/not-taken, computes the redirect target, and generates the R7 link write for JAL/JALR. It also runs a flush FSM that squashes the younger instructions already fetched under the predict-not-taken policy.

## Interface
- WIDTH, 16, datapath/PC width
- FLUSH_DEPTH, 2, cycles of squash after a taken redirect (IF+ID); legal range 1..7

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  control-flow instruction present in EX this cycle
- stall  in  1  pipeline hold; block freezes all state
- aluOp  in  5  opcode: 01100 BEQZ, 01101 BNEZ, 01110 BLTZ, 01111 BGEZ, 00100 J, 00110 JAL, 00101 JR, 00111 JALR
- alu_cond  in  1  ALU condition result for the branch (1 = condition true)
- pc_plus2  in  WIDTH  address of the next sequential instruction
- imm  in  WIDTH  sign-extended displacement
- rs_val  in  WIDTH  forwarded Rs value (JR/JALR base)
- redirect  out  1  fetch must load target
- target  out  WIDTH  redirect address
- flush  out  1  squash IF/ID contents
- link_we  out  1  write link_data to R7
- link_data  out  WIDTH  return address
- err  out  1  sticky illegal-opcode flag
- taken_cnt  out  16  saturating count of taken redirects

## Operation
- Accept condition: in_valid & !stall & state==IDLE.
- Taken: the four branches are taken iff alu_cond=1; J, JAL, JR, JALR are always taken.
- Target: branches and J/JAL use pc_plus2+imm. JR/JALR use rs_val+imm. Addition is modulo 2^WIDTH and wraps with no overflow flag.
- Link: JAL/JALR set link_we=1 and link_data=pc_plus2. Link is issued regardless of branch outcome logic, since these ops are always taken.
- Not-taken branch: redirect=0, flush=0, link_we=0, state stays IDLE.
- Illegal aluOp on accept: err set and sticky until reset. The instruction is treated as not-taken and produces no link.
- FSM states:
  - IDLE: a taken accept loads cnt=FLUSH_DEPTH-1 and moves to FLUSH.
  - FLUSH: each unstalled cycle with cnt==0 returns to IDLE; otherwise cnt decrements.
  - in_valid is ignored in FLUSH because those instructions are being squashed.
- taken_cnt increments on each taken accept and saturates at 0xFFFF.
- Reset values: redirect=0, target=0, flush=0, link_we=0, link_data=0, err=0, taken_cnt=0, state=IDLE, cnt=0.

## Timing
- All outputs are registered.
- Latency: an accept in cycle N produces outputs in cycle N+1.
- Redirect and link:
  - redirect and link_we are one-cycle pulses in N+1 when there is no stall.
  - target and link_data hold their last value until the next accept.
- Flush:
  - flush is high in cycles N+1 through N+FLUSH_DEPTH, exactly FLUSH_DEPTH unstalled cycles.
  - flush is high for exactly the cycles in which the FSM is in FLUSH.
- Stall in any cycle: state, cnt and every output register hold, including a pending redirect/link_we pulse. Consumers qualify these outputs with !stall.
- Back-to-back not-taken branches are accepted every cycle with zero bubbles.
- in_valid in the last FLUSH cycle is ignored. The first accept is possible in the cycle after flush falls.
- rst_n low at any edge, including mid-FLUSH or with a pending pulse: all outputs reach reset values in the next cycle. rst_n dominates stall.

## Test plan
- BEQZ, alu_cond=1, pc_plus2=0x0010, imm=0xFFF8 → next cycle redirect=1, target=0x0008, flush=1 for 2 cycles, link_we=0, taken_cnt=1.
- BNEZ, alu_cond=0 on three consecutive cycles → redirect=0, flush=0 throughout, all three accepted, taken_cnt unchanged.
- JALR, rs_val=0xFFFE, imm=0x0004, pc_plus2=0x0100 → target=0x0002 (wraps), link_we=1, link_data=0x0100. A JAL presented on the following two cycles is ignored (FLUSH).
- J taken with stall asserted for 3 cycles right after accept → redirect=1 and flush=1 held during the stall. Flush then lasts 2 unstalled cycles in total.
- rst_n low during the first FLUSH cycle → next cycle flush=0, redirect=0, state IDLE. A BLTZ taken immediately after reset is accepted.
- aluOp=00011 with in_valid → err=1 and sticky, redirect=0. err clears only on rst_n.
